// File: rtl/aes256_round_key_store.sv
// AES-256 round-key cache: captures the expander's NR+1 round keys once per key load and
// serves them by round index. Optional macro AES_RKS_EQINV_EN applies InvMixColumns to middle inverse keys.
module aes256_round_key_store #(
  parameter int NR   = 14,
  parameter int RK_W = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cap_start,
  input  logic            rk_valid,
  input  logic [RK_W-1:0] rk_in,
  output logic            keys_ready,
  output logic            filling,
  input  logic            rd_req,
  input  logic [3:0]      rd_round,
  input  logic            rd_inv,
  output logic            rd_valid,
  output logic [RK_W-1:0] rd_key,
  output logic            rd_err,
  output logic            ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_READY = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_wr_ptr;
  logic [RK_W-1:0] r_store [0:NR];
  logic            r_ovf;
  logic            r_rd_valid;
  logic            r_rd_err;
  logic [RK_W-1:0] r_rd_key;

  logic            w_wr_en;
  logic            w_fill_done;
  logic            w_rd_in_range;
  logic            w_rd_legal;
  logic            w_rd_illegal;
  logic [3:0]      w_rd_idx;
  logic [RK_W-1:0] w_rd_raw;
  logic [RK_W-1:0] w_rd_data;

`ifdef AES_RKS_EQINV_EN
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Byte 0 of each column sits in the most significant position (FIPS-197 byte order).
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   b0, b1, b2, b3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      b0 = s[127 - 32*c -: 8];
      b1 = s[119 - 32*c -: 8];
      b2 = s[111 - 32*c -: 8];
      b3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 8] = mul14(b0) ^ mul11(b1) ^ mul13(b2) ^ mul9(b3);
      r[119 - 32*c -: 8] = mul9(b0)  ^ mul14(b1) ^ mul11(b2) ^ mul13(b3);
      r[111 - 32*c -: 8] = mul13(b0) ^ mul9(b1)  ^ mul14(b2) ^ mul11(b3);
      r[103 - 32*c -: 8] = mul11(b0) ^ mul13(b1) ^ mul9(b2)  ^ mul14(b3);
    end
    return r;
  endfunction
`endif

  // cap_start always wins over a same-cycle rk_valid or rd_req.
  assign w_wr_en     = (r_state == S_FILL) && rk_valid && !cap_start;
  assign w_fill_done = w_wr_en && (r_wr_ptr == LAST_IDX);

  always_comb begin
    w_state_nxt = r_state;
    if (cap_start) begin
      w_state_nxt = S_FILL;
    end else if (w_fill_done) begin
      w_state_nxt = S_READY;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (cap_start) begin
        r_wr_ptr <= '0;
      end else if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 4'd1;
      end
    end
  end

  // NOTE: the key array is not reset; it is unreadable until a full schedule is written.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_store[r_wr_ptr] <= rk_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (cap_start) begin
      r_ovf <= 1'b0;
    end else if ((r_state == S_READY) && rk_valid) begin
      r_ovf <= 1'b1;
    end
  end

  // Inverse index is formed only for in-range rounds so it never underflows.
  assign w_rd_in_range = (rd_round <= LAST_IDX);
  assign w_rd_idx      = !w_rd_in_range ? 4'd0 :
                         rd_inv         ? (LAST_IDX - rd_round) : rd_round;
  assign w_rd_legal    = rd_req && !cap_start && (r_state == S_READY) && w_rd_in_range;
  assign w_rd_illegal  = rd_req && !cap_start && !w_rd_legal;
  assign w_rd_raw      = r_store[w_rd_idx];

`ifdef AES_RKS_EQINV_EN
  assign w_rd_data = (rd_inv && (w_rd_idx != 4'd0) && (w_rd_idx != LAST_IDX))
                     ? inv_mix_columns(w_rd_raw) : w_rd_raw;
`else
  assign w_rd_data = w_rd_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rd_key   <= '0;
    end else begin
      r_rd_valid <= w_rd_legal;
      r_rd_err   <= w_rd_illegal;
      if (w_rd_legal) begin
        r_rd_key <= w_rd_data;
      end
    end
  end

  assign keys_ready = (r_state == S_READY);
  assign filling    = (r_state == S_FILL);
  assign rd_valid   = r_rd_valid;
  assign rd_err     = r_rd_err;
  assign rd_key     = r_rd_key;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_aes256_round_key_store.sv
// Self-checking bench for aes256_round_key_store: directed steps plus random reads,
// each cycle compared against a behavioural store model.
`timescale 1ns/1ps
module tb_aes256_round_key_store;
  localparam int NR = 14;
  localparam int NK = NR + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cap_start = 1'b0;
  logic         rk_valid = 1'b0;
  logic [127:0] rk_in = '0;
  logic         rd_req = 1'b0;
  logic [3:0]   rd_round = '0;
  logic         rd_inv = 1'b0;
  logic         keys_ready, filling, rd_valid, rd_err, ovf;
  logic [127:0] rd_key;

  always #5 clk = ~clk;

  aes256_round_key_store #(.NR(NR), .RK_W(128)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap_start  (cap_start),
    .rk_valid   (rk_valid),
    .rk_in      (rk_in),
    .keys_ready (keys_ready),
    .filling    (filling),
    .rd_req     (rd_req),
    .rd_round   (rd_round),
    .rd_inv     (rd_inv),
    .rd_valid   (rd_valid),
    .rd_key     (rd_key),
    .rd_err     (rd_err),
    .ovf        (ovf)
  );

  int checks = 0;
  int failures = 0;

  // Model: a captured-key list plus a count of keys received since the last capture start.
  logic [127:0] m_store [NK];
  bit           m_active;
  int           m_count;
  bit           m_ovf;
  bit           m_valid;
  bit           m_err;
  logic [127:0] m_key;
  logic [127:0] sched [NK];

  function automatic bit m_ready();
    return m_active && (m_count == NK);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

`ifdef AES_RKS_EQINV_EN
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] k);
    logic [7:0]   coef [4];
    logic [7:0]   a [4];
    logic [7:0]   o;
    logic [127:0] r;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) a[rr] = k[127 - 8*(4*c + rr) -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        o = '0;
        for (int j = 0; j < 4; j++) o ^= gmul(a[j], coef[(j - rr + 4) % 4]);
        r[127 - 8*(4*c + rr) -: 8] = o;
      end
    end
    return r;
  endfunction
`endif

  task automatic model_reset();
    m_active = 1'b0;
    m_count  = 0;
    m_ovf    = 1'b0;
    m_valid  = 1'b0;
    m_err    = 1'b0;
    m_key    = '0;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".keys_ready"}, 128'(keys_ready), 128'(m_ready()));
    check({tag, ".filling"},    128'(filling),    128'(m_active && (m_count < NK)));
    check({tag, ".rd_valid"},   128'(rd_valid),   128'(m_valid));
    check({tag, ".rd_err"},     128'(rd_err),     128'(m_err));
    check({tag, ".ovf"},        128'(ovf),        128'(m_ovf));
    check({tag, ".rd_key"},     rd_key,           m_key);
  endtask

  // One clock cycle: drive at the falling edge, update the model, compare at the next falling edge.
  task automatic step(input bit cap, input bit rkv, input logic [127:0] rk,
                      input bit req, input logic [3:0] rnd, input bit inv, input string tag);
    int idx;
    cap_start = cap;
    rk_valid  = rkv;
    rk_in     = rk;
    rd_req    = req;
    rd_round  = rnd;
    rd_inv    = inv;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (req && !cap) begin
      if (m_ready() && (int'(rnd) <= NR)) begin
        idx     = inv ? (NR - int'(rnd)) : int'(rnd);
        m_valid = 1'b1;
        m_key   = m_store[idx];
`ifdef AES_RKS_EQINV_EN
        if (inv && (idx > 0) && (idx < NR)) m_key = inv_mix(m_store[idx]);
`endif
      end else begin
        m_err = 1'b1;
      end
    end
    if (cap) begin
      m_active = 1'b1;
      m_count  = 0;
      m_ovf    = 1'b0;
    end else if (rkv) begin
      if (m_active && (m_count < NK)) begin
        m_store[m_count] = rk;
        m_count++;
      end else if (m_ready()) begin
        m_ovf = 1'b1;
      end
    end
    @(negedge clk);
    cap_start = 1'b0;
    rk_valid  = 1'b0;
    rd_req    = 1'b0;
    check_outputs(tag);
  endtask

  task automatic random_reads(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, '0, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), tag);
    end
  endtask

  initial begin
    model_reset();
    sched[0]      = 128'h000102030405060708090a0b0c0d0e0f;
    sched[1]      = 128'h101112131415161718191a1b1c1d1e1f;
    sched[NK - 1] = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    for (int i = 2; i < NK - 1; i++) sched[i] = rand128();

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_outputs("reset");

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rand128(), 1'b0, 4'd0, 1'b0, "idle_rk");
    step(1'b0, 1'b0, '0, 1'b1, 4'd0, 1'b0, "idle_rd");

    step(1'b1, 1'b0, '0, 1'b0, 4'd0, 1'b0, "cap");
    for (int i = 0; i < NK; i++) step(1'b0, 1'b1, sched[i], 1'b0, 4'd0, 1'b0, "fill");

    step(1'b0, 1'b0, '0, 1'b1, 4'd0, 1'b0, "rd_r0");
    check("fips_r0", rd_key, 128'h000102030405060708090a0b0c0d0e0f);
    step(1'b0, 1'b0, '0, 1'b1, 4'd1, 1'b0, "rd_r1");
    check("fips_r1", rd_key, 128'h101112131415161718191a1b1c1d1e1f);
    step(1'b0, 1'b0, '0, 1'b1, 4'd0, 1'b1, "rd_inv0");
    check("fips_inv0", rd_key, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    step(1'b0, 1'b0, '0, 1'b0, 4'd0, 1'b0, "rd_hold");
    step(1'b0, 1'b0, '0, 1'b1, 4'd15, 1'b0, "rd_oor");
    step(1'b0, 1'b0, '0, 1'b1, 4'd15, 1'b1, "rd_oor_inv");
    step(1'b0, 1'b0, '0, 1'b0, 4'd0, 1'b0, "err_pulse");
    for (int r = 0; r < NK; r++) step(1'b0, 1'b0, '0, 1'b1, 4'(r), 1'b1, "sweep_inv");
    random_reads(60, "rd_rand");

    step(1'b0, 1'b1, rand128(), 1'b0, 4'd0, 1'b0, "ovf_set");
    random_reads(10, "rd_after_ovf");
    step(1'b1, 1'b0, '0, 1'b1, 4'd3, 1'b0, "cap_with_rd");

    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, rand128(), 1'b0, 4'd0, 1'b0, "partial");
    step(1'b1, 1'b1, rand128(), 1'b0, 4'd0, 1'b0, "cap_with_rk");
    for (int i = 0; i < NK; i++) sched[i] = rand128();
    for (int i = 0; i < NK; i++)
      step(1'b0, 1'b1, sched[i], (i % 3 == 0), 4'(i), 1'b0, "refill");
    random_reads(40, "rd_new");
    step(1'b0, 1'b1, rand128(), 1'b0, 4'd0, 1'b0, "ovf2_set");
    step(1'b1, 1'b0, '0, 1'b0, 4'd0, 1'b0, "ovf2_clear");

    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, rand128(), 1'b0, 4'd0, 1'b0, "pre_rst");
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs("rst_release");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rand128(), 1'b0, 4'd0, 1'b0, "post_rst_rk");
    step(1'b0, 1'b0, '0, 1'b1, 4'd2, 1'b0, "post_rst_rd");

    step(1'b1, 1'b0, '0, 1'b0, 4'd0, 1'b0, "cap3");
    for (int i = 0; i < NK; i++) sched[i] = rand128();
    for (int i = 0; i < NK; i++) step(1'b0, 1'b1, sched[i], 1'b0, 4'd0, 1'b0, "fill3");
    random_reads(30, "rd_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
